// File: rtl/reg_timeout_guard_pkg.sv
// Regbus request/response types and sizing helpers shared by the timeout guard.
package reg_timeout_guard_pkg;

    localparam int unsigned RegAddrWidth = 32;
    localparam int unsigned RegDataWidth = 32;

    typedef struct packed {
        logic [RegAddrWidth-1:0]   addr;
        logic                      write;
        logic [RegDataWidth-1:0]   wdata;
        logic [RegDataWidth/8-1:0] wstrb;
        logic                      valid;
    } regbus_req_t;

    typedef struct packed {
        logic [RegDataWidth-1:0] rdata;
        logic                    error;
        logic                    ready;
    } regbus_rsp_t;

    // A disabled watchdog still gets a 1-bit counter so no port collapses to zero width.
    function automatic int unsigned stall_cnt_width(input int unsigned cycles);
        if (cycles == 0) return 1;
        return unsigned'($clog2(cycles + 1));
    endfunction

endpackage

// File: rtl/reg_timeout_guard_counter.sv
// Stall counter with synchronous clear (priority) and count enable.
module reg_timeout_guard_counter #(
    parameter int unsigned Width = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [Width-1:0] cnt_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + Width'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/reg_timeout_guard.sv
// Regbus watchdog: pass-through until the downstream stalls too long, then answers
// upstream with an error and drains the stuck request downstream on its own.
module reg_timeout_guard
    import reg_timeout_guard_pkg::*;
#(
    parameter int unsigned          TimeoutCycles = 1024,
    parameter int unsigned          DataWidth     = 32,
    parameter logic [DataWidth-1:0] TimeoutRdata  = DataWidth'(32'hBADCAB1E),
    parameter int unsigned          StatWidth     = 16,
    parameter type                  reg_req_t     = regbus_req_t,
    parameter type                  reg_rsp_t     = regbus_rsp_t
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  reg_req_t             reg_req_i,
    output reg_rsp_t             reg_rsp_o,
    output reg_req_t             reg_req_o,
    input  reg_rsp_t             reg_rsp_i,
    input  logic                 stat_clr_i,
    output logic                 timeout_o,
    output logic                 draining_o,
    output logic [StatWidth-1:0] timeout_cnt_o
);

    localparam int unsigned          CntWidth   = stall_cnt_width(TimeoutCycles);
    localparam logic [CntWidth-1:0]  TimeoutVal = CntWidth'(TimeoutCycles);
    localparam bit                   WdEnable   = (TimeoutCycles != 0);

    localparam logic StPass  = 1'b0;
    localparam logic StDrain = 1'b1;

    if (TimeoutCycles >= (1 << 20)) begin : g_bad_timeout
        $error("TimeoutCycles must be below 2**20");
    end
    if ($bits(reg_rsp_o.rdata) != DataWidth) begin : g_bad_width
        $error("DataWidth does not match the response rdata width");
    end

    logic                 state_q, state_d;
    reg_req_t             req_q, req_d;
    logic [StatWidth-1:0] stat_q, stat_d;
    logic [CntWidth-1:0]  cnt_q;
    logic                 cnt_clr, cnt_en;
    logic                 timeout;

    reg_timeout_guard_counter #(
        .Width (CntWidth)
    ) i_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (cnt_clr),
        .en_i  (cnt_en),
        .cnt_o (cnt_q)
    );

    // A genuine downstream ready in the same cycle always beats the timeout.
    assign timeout = WdEnable && (state_q == StPass) && reg_req_i.valid &&
                     !reg_rsp_i.ready && (cnt_q == TimeoutVal);

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        reg_req_o = reg_req_i;
        reg_rsp_o = reg_rsp_i;
        cnt_clr   = 1'b1;
        cnt_en    = 1'b0;
        case (state_q)
            StPass: begin
                if (timeout) begin
                    reg_rsp_o       = '0;
                    reg_rsp_o.ready = 1'b1;
                    reg_rsp_o.error = 1'b1;
                    reg_rsp_o.rdata = reg_req_i.write ? '0 : TimeoutRdata;
                    req_d           = reg_req_i;
                    state_d         = StDrain;
                end else if (WdEnable && reg_req_i.valid && !reg_rsp_i.ready) begin
                    cnt_clr = 1'b0;
                    cnt_en  = 1'b1;
                end
            end
            default: begin
                // Keep the stuck request alive downstream; its late response is swallowed.
                reg_req_o       = req_q;
                reg_req_o.valid = 1'b1;
                reg_rsp_o       = '0;
                if (reg_rsp_i.ready) begin
                    state_d = StPass;
                end
            end
        endcase
    end

    always_comb begin
        stat_d = stat_q;
        if (stat_clr_i) begin
            stat_d = '0;
        end else if (timeout && !(&stat_q)) begin
            stat_d = stat_q + StatWidth'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StPass;
            req_q   <= '0;
            stat_q  <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            stat_q  <= stat_d;
        end
    end

    assign timeout_o     = timeout;
    assign draining_o    = (state_q == StDrain);
    assign timeout_cnt_o = stat_q;

endmodule

// File: tb/tb_reg_timeout_guard.sv
// Scoreboard bench for reg_timeout_guard: a transaction-level model predicts each
// upstream response (cycle, data, error, timeout) plus drain windows and the stat count.
module tb_reg_timeout_guard;
    import reg_timeout_guard_pkg::*;

    localparam int T    = 8;
    localparam int SW   = 2;
    localparam int NCYC = 16384;

    typedef struct {
        int          cyc;
        logic [31:0] rdata;
        logic        err;
        logic        tmo;
    } exp_t;

    typedef struct {
        int          lat;
        logic [31:0] rdata;
        logic        err;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        write;
    } slv_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    regbus_req_t req_i, req_o;
    regbus_rsp_t rsp_o, rsp_i;
    logic        stat_clr = 1'b0;
    logic        tmo_o, drn_o;
    logic [SW-1:0] tcnt_o;

    regbus_req_t req0_i, req0_o;
    regbus_rsp_t rsp0_o, rsp0_i;
    logic        clr0 = 1'b0;
    logic        tmo0_o, drn0_o;
    logic [15:0] tcnt0_o;

    reg_timeout_guard #(.TimeoutCycles(T), .StatWidth(SW)) u_dut (
        .clk_i(clk), .rst_i(rst), .reg_req_i(req_i), .reg_rsp_o(rsp_o),
        .reg_req_o(req_o), .reg_rsp_i(rsp_i), .stat_clr_i(stat_clr),
        .timeout_o(tmo_o), .draining_o(drn_o), .timeout_cnt_o(tcnt_o)
    );

    reg_timeout_guard #(.TimeoutCycles(0)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .reg_req_i(req0_i), .reg_rsp_o(rsp0_o),
        .reg_req_o(req0_o), .reg_rsp_i(rsp0_i), .stat_clr_i(clr0),
        .timeout_o(tmo0_o), .draining_o(drn0_o), .timeout_cnt_o(tcnt0_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];
    slv_t slv_q[$];
    bit   exp_drain[NCYC];
    bit   clr_sched[NCYC];
    bit   mon_en = 1'b0;
    bit   slv_en = 1'b0;
    int   drain_exit = -100;
    int   mdl_tcnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    always @(posedge clk) begin
        #1;
        stat_clr = (cyc < NCYC) ? clr_sched[cyc] : 1'b0;
    end

    // Downstream slave: answers each forwarded request after its scheduled latency.
    initial begin : slave
        slv_t cur;
        bit   act;
        int   k;
        act   = 1'b0;
        k     = 0;
        rsp_i = '0;
        forever begin
            @(posedge clk);
            #2;
            rsp_i.ready = 1'b0;
            rsp_i.error = 1'b0;
            rsp_i.rdata = $urandom;
            if (!slv_en) begin
                act = 1'b0;
            end else if (req_o.valid) begin
                if (!act) begin
                    if (slv_q.size() == 0) begin
                        fail_now("dn_unexpected_request");
                    end else begin
                        cur = slv_q.pop_front();
                        act = 1'b1;
                        k   = 0;
                    end
                end else begin
                    k++;
                end
                if (act && k == cur.lat) begin
                    chk("dn_addr", req_o.addr, cur.addr);
                    chk("dn_write", {31'b0, req_o.write}, {31'b0, cur.write});
                    chk("dn_wdata", req_o.wdata, cur.wdata);
                    chk("dn_wstrb", {28'b0, req_o.wstrb}, 32'hF);
                    rsp_i.ready = 1'b1;
                    rsp_i.rdata = cur.rdata;
                    rsp_i.error = cur.err;
                    act = 1'b0;
                end
            end
        end
    end

    // Upstream monitor: pops the scoreboard whenever the DUT answers upstream.
    initial begin : monitor
        exp_t e;
        bit   tmo_now;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("timeout_cnt", {30'b0, tcnt_o}, mdl_tcnt);
                chk("draining", {31'b0, drn_o}, (cyc < NCYC) ? {31'b0, exp_drain[cyc]} : 32'h0);
                tmo_now = 1'b0;
                if (rsp_o.ready) begin
                    if (exp_q.size() == 0) begin
                        fail_now("spurious_upstream_ready");
                    end else begin
                        e = exp_q.pop_front();
                        chk("rsp_cycle", cyc, e.cyc);
                        chk("rsp_rdata", rsp_o.rdata, e.rdata);
                        chk("rsp_error", {31'b0, rsp_o.error}, {31'b0, e.err});
                        tmo_now = e.tmo;
                    end
                end
                chk("timeout_pulse", {31'b0, tmo_o}, {31'b0, tmo_now});
                if (stat_clr) mdl_tcnt = 0;
                else if (tmo_now && mdl_tcnt < (1 << SW) - 1) mdl_tcnt++;
            end
        end
    end

    // Issue one upstream transaction after `gap` idle cycles; slave answers after `lat`.
    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input int lat, input logic [31:0] rdata, input logic err,
                         input int gap, input bit clr_at_resp);
        int   s, f, rc, n;
        exp_t e;
        slv_t c;
        repeat (gap) begin
            req_i.valid = 1'b0;
            @(posedge clk);
            #1;
        end
        s = cyc;
        f = (s > drain_exit) ? s : drain_exit + 1;
        c = '{lat, rdata, err, addr, wdata, wr};
        slv_q.push_back(c);
        if (lat > T) begin
            rc = f + T;
            e  = '{rc, (wr ? 32'h0 : 32'hBADCAB1E), 1'b1, 1'b1};
            for (int i = rc + 1; i <= f + lat; i++) if (i < NCYC) exp_drain[i] = 1'b1;
            drain_exit = f + lat;
        end else begin
            rc = f + lat;
            e  = '{rc, rdata, err, 1'b0};
        end
        if (clr_at_resp && rc > s && rc < NCYC) clr_sched[rc] = 1'b1;
        exp_q.push_back(e);
        req_i.addr  = addr;
        req_i.write = wr;
        req_i.wdata = wdata;
        req_i.wstrb = 4'hF;
        req_i.valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (rsp_o.ready) break;
            n++;
            if (n > 200) begin
                fail_now("upstream_ready_wait_expired");
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        req_i.valid = 1'b0;
    endtask

    task automatic idle_until_drained();
        int n;
        n = 0;
        while (cyc <= drain_exit + 1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL global_time_limit (cycle %0d)", cyc);
        $fatal(1, "simulation time limit reached");
    end

    initial begin : main
        int n;
        req_i  = '0;
        req0_i = '0;
        rsp0_i = '0;
        rst    = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_rsp_ready", {31'b0, rsp_o.ready}, 32'h0);
        chk("reset_timeout", {31'b0, tmo_o}, 32'h0);
        chk("reset_draining", {31'b0, drn_o}, 32'h0);
        chk("reset_tcnt", {30'b0, tcnt_o}, 32'h0);
        chk("reset_dn_valid", {31'b0, req_o.valid}, 32'h0);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        slv_en = 1'b1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // Directed scenarios
        issue(1'b0, 32'h100, 32'h0, 3, 32'h1234_5678, 1'b0, 0, 1'b0);
        issue(1'b0, 32'h104, 32'h0, 20, 32'h0, 1'b0, 0, 1'b0);
        issue(1'b1, 32'h108, 32'h0000_A5A5, 2, 32'h0, 1'b0, 3, 1'b0);
        issue(1'b0, 32'h10C, 32'h0, 8, 32'hCAFE_0001, 1'b0, 1, 1'b0);
        for (int i = 0; i < 4; i++)
            issue(i[0], 32'h200 + 32'(4 * i), 32'(i), 9, 32'h0, 1'b0, 0, 1'b0);
        idle_until_drained();
        if (cyc + 2 < NCYC) clr_sched[cyc + 2] = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        issue(1'b0, 32'h300, 32'h0, 10, 32'h0, 1'b0, 0, 1'b0);
        issue(1'b1, 32'h304, 32'h77, 12, 32'h0, 1'b0, 1, 1'b1);
        idle_until_drained();

        // Randomized traffic
        for (int t = 0; t < 60; t++) begin
            if ($urandom_range(0, 9) == 0 && cyc + 16 < NCYC)
                clr_sched[cyc + int'($urandom_range(1, 15))] = 1'b1;
            issue(1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, $urandom,
                  int'($urandom_range(0, 14)), $urandom, ($urandom_range(0, 3) == 0),
                  int'($urandom_range(0, 3)), ($urandom_range(0, 5) == 0));
        end
        idle_until_drained();
        repeat (20) begin
            @(posedge clk);
            #1;
        end
        chk("scoreboard_empty", exp_q.size(), 32'h0);
        chk("slave_queue_empty", slv_q.size(), 32'h0);

        // Reset while draining
        mon_en = 1'b0;
        slv_en = 1'b0;
        @(posedge clk);
        #1;
        req_i.addr  = 32'h400;
        req_i.write = 1'b0;
        req_i.valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (rsp_o.ready || n > 50) break;
            n++;
        end
        chk("rst_phase_timeout_pulse", {31'b0, tmo_o}, 32'h1);
        @(posedge clk);
        #1;
        req_i.valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_phase_draining", {31'b0, drn_o}, 32'h1);
        chk("rst_phase_dn_valid", {31'b0, req_o.valid}, 32'h1);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_dn_valid", {31'b0, req_o.valid}, 32'h0);
        chk("async_rst_draining", {31'b0, drn_o}, 32'h0);
        chk("async_rst_tcnt", {30'b0, tcnt_o}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Watchdog disabled instance with a stalled slave
        req0_i.addr  = 32'h500;
        req0_i.write = 1'b0;
        req0_i.wstrb = 4'hF;
        req0_i.valid = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            chk("wd0_no_timeout", {31'b0, tmo0_o}, 32'h0);
            chk("wd0_no_ready", {31'b0, rsp0_o.ready}, 32'h0);
        end
        chk("wd0_dn_valid", {31'b0, req0_o.valid}, 32'h1);
        chk("wd0_dn_addr", req0_o.addr, 32'h500);
        @(posedge clk);
        #1;
        rsp0_i.ready = 1'b1;
        rsp0_i.rdata = 32'hCAFE_F00D;
        #1;
        chk("wd0_pass_ready", {31'b0, rsp0_o.ready}, 32'h1);
        chk("wd0_pass_rdata", rsp0_o.rdata, 32'hCAFE_F00D);
        chk("wd0_pass_error", {31'b0, rsp0_o.error}, 32'h0);
        @(posedge clk);
        #1;
        rsp0_i.ready = 1'b0;
        req0_i.valid = 1'b0;
        @(negedge clk);
        chk("wd0_tcnt", {16'b0, tcnt0_o}, 32'h0);
        chk("wd0_draining", {31'b0, drn0_o}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
